mul_div_seq_ctrl: RTL
=====================

// Module: mul_div_seq_ctrl
// PURPOSE
//  Sequencer that time-shares one add_sub_nbits datapath to run ADD, SUB, unsigned MUL and unsigned DIV.
//  MUL is iterative shift-add and DIV is iterative restoring division; both take one adder pass per bit.
//  Sits between the calculator command decoder (start/op/operands) and the result/display register stage.
// PARAMETERS
//  width   8   operand width in bits; must be >= 2
// PORTS
//  clk_i          in   1        single clock, rising edge
//  rst_n_i        in   1        asynchronous, active-low reset
//  start_i        in   1        request; sampled only in IDLE
//  op_i           in   2        operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV
//  a_i            in   width    operand A (dividend for DIV)
//  b_i            in   width    operand B (divisor for DIV)
//  busy_o         out  1        high whenever state != IDLE
//  done_o         out  1        one-cycle pulse: results valid
//  res_lo_o       out  width    ADD/SUB sum; MUL product[width-1:0]; DIV quotient
//  res_hi_o       out  width    ADD/SUB 0; MUL product[2w-1:w]; DIV remainder
//  cout_o         out  1        ADD carry / SUB borrow; 0 for MUL and DIV
//  div_zero_o     out  1        DIV with b_i==0
// BEHAVIOUR
//  Reset: state=IDLE; busy_o, done_o, cout_o, div_zero_o = 0; res_lo_o = res_hi_o = 0.
//  FSM: IDLE -> ITER -> DONE -> IDLE.
//   IDLE: on start_i=1, latch op_i/a_i/b_i, clear the accumulator, load counter, go to ITER.
//   ITER: one adder pass per cycle. ADD/SUB take N=1 cycle. MUL/DIV take N=width cycles; the counter counts down to 0.
//   DONE: update result registers and flags on entry; done_o=1 for exactly this cycle; then go to IDLE.
//  Latency: start sampled at edge k -> done_o high in the cycle after edge k+N+1.
//   Back-to-back: the next start can be accepted at the edge that leaves DONE+1, i.e. once in IDLE.
//  start_i while busy_o=1: ignored; no queueing.
//  Operand and op changes after acceptance have no effect, because the operands are latched.
//  Outputs hold the last results until the next DONE; they are not cleared on a new start.
//  Datapath: one add_sub_nbits instance of width+1, with operands zero-extended.
//   MUL: if multiplier LSB=1, add B to the accumulator high half. Then shift {cout,acc_hi,mult} right 1.
//   DIV: shift {rem,quot} left 1, then trial-subtract B from rem. If there is no borrow, keep the difference and set quot[0]=1. Otherwise restore rem and set quot[0]=0.
//   SUB: cout_o=1 means borrow (a_i<b_i). The result is modulo 2^width.
//  DIV by zero: skip ITER and go IDLE->DONE directly.
//   res_lo_o = all ones, res_hi_o = a_i, div_zero_o=1.
//   div_zero_o is cleared at the next DONE for any other op.
//  Reset mid-operation: abandon immediately; all outputs take their reset values.
// CONFIGURATION
//  MUL_DIV_ABORT_EN defined:
//   Adds port abort_i (in, 1).
//   abort_i=1 in ITER -> IDLE at the next edge, with no done_o.
//   res_*/flags keep their previous values. abort_i is ignored in IDLE and DONE.
//  MUL_DIV_ABORT_EN undefined: no abort_i port; an operation always runs to DONE.
// STRUCTURE
//  Shared package calc_pkg:
//   op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
//   state_e enum (S_IDLE, S_ITER, S_DONE).
//  Submodule: add_sub_nbits #(.width(width+1)) u_addsub. No other submodule; the FSM and shift registers are local.
//  Counter width: $clog2(width)+1.
// TESTING (width=8)
//  ADD a=200 b=100 -> res_lo=44, cout=1, res_hi=0; done_o 2 cycles after start edge; busy_o high meanwhile.
//  SUB a=5 b=7 -> res_lo=254, cout=1. Also SUB a=7 b=5 -> res_lo=2, cout=0.
//  MUL 255*255 -> res_hi=0xFE, res_lo=0x01 after 9 cycles. MUL 0*x -> 0.
//  DIV 100/7 -> quot=14, rem=2, div_zero=0.
//   DIV 13/0 -> res_lo=0xFF, res_hi=13, div_zero=1, done 1 cycle after start edge.
//  start pulsed during MUL ITER with new operands -> ignored; first result unchanged, only one done_o.
//  rst_n_i low mid-DIV -> all outputs 0 asynchronously; a new op after release completes correctly.
//  With MUL_DIV_ABORT_EN: abort_i at ITER cycle 3 of MUL -> IDLE next edge, no done_o, previous results held.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: operation codes and FSM states.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ITER = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // MUL and DIV run one adder pass per operand bit; ADD and SUB need one pass.
   function automatic logic is_iterative(op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/add_sub_nbits.sv
// Plain ripple-style adder/subtractor: sum = a + b, or a - b as a + ~b + 1.
// cout_o is the carry out of the top bit (for subtraction, 1 means no borrow).
module add_sub_nbits #(
   parameter int width = 9
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   input  logic             sub_i,
   output logic [width-1:0] sum_o,
   output logic             cout_o
);

   logic [width:0] full;

   // Single carry chain shared by add and subtract.
   assign full   = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{width{1'b0}}, sub_i};
   assign sum_o  = full[width-1:0];
   assign cout_o = full[width];

endmodule

// File: rtl/mul_div_seq_ctrl.sv
// Sequencer time-sharing one width+1 adder for ADD, SUB, unsigned MUL
// (shift-add) and unsigned DIV (restoring). Optional abort port is
// enabled by defining MUL_DIV_ABORT_EN.
module mul_div_seq_ctrl
   import calc_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
`ifdef MUL_DIV_ABORT_EN
   input  logic             abort_i,
`endif
   input  logic [1:0]       op_i,
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [width-1:0] res_lo_o,
   output logic [width-1:0] res_hi_o,
   output logic             cout_o,
   output logic             div_zero_o
);

   localparam int CNT_W = $clog2(width) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(width);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state, state_nxt;
   op_e              op_in, op_q;
   logic [CNT_W-1:0] cnt;
   logic [width:0]   acc, acc_nxt, mul_sum;
   logic [width-1:0] lo, lo_nxt, b_q;
   logic [width:0]   add_x, add_y, add_sum;
   logic             add_sub, add_cout;
   logic             abort_w, div_by_zero, accept, finish, pass;

`ifdef MUL_DIV_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   assign op_in       = op_e'(op_i);
   assign div_by_zero = (op_in == OP_DIV) && (b_i == '0);
   assign accept      = (state == S_IDLE) && start_i;
   assign pass        = (state == S_ITER) && (cnt != '0);
   assign finish      = (state == S_ITER) && (cnt == '0) && !abort_w;

   assign busy_o = (state != S_IDLE);
   assign done_o = (state == S_DONE);

   add_sub_nbits #(.width(width + 1)) u_addsub (
      .a_i    (add_x),
      .b_i    (add_y),
      .sub_i  (add_sub),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // Next-state logic; a zero divisor bypasses the iteration entirely.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (start_i) state_nxt = div_by_zero ? S_DONE : S_ITER;
         S_ITER: begin
            if (abort_w)        state_nxt = S_IDLE;
            else if (cnt == '0) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register and pass counter (counts remaining adder passes).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)    cnt <= is_iterative(op_in) ? CNT_FULL : CNT_ONE;
         else if (pass) cnt <= cnt - CNT_ONE;
      end
   end

   // One adder pass: operand steering and the shift for MUL/DIV.
   always_comb begin
      add_x   = acc;
      add_y   = {1'b0, b_q};
      add_sub = 1'b0;
      acc_nxt = acc;
      lo_nxt  = lo;
      mul_sum = acc;
      unique case (op_q)
         OP_ADD: begin
            add_x   = {1'b0, lo};
            acc_nxt = add_sum;
         end
         OP_SUB: begin
            add_x   = {1'b0, lo};
            add_sub = 1'b1;
            acc_nxt = add_sum;
         end
         OP_MUL: begin
            mul_sum = lo[0] ? add_sum : acc;
            acc_nxt = {1'b0, mul_sum[width:1]};
            lo_nxt  = {mul_sum[0], lo[width-1:1]};
         end
         OP_DIV: begin
            // Shift {rem,quot} left, then trial-subtract; carry out means no borrow.
            add_x   = {acc[width-1:0], lo[width-1]};
            add_sub = 1'b1;
            if (add_cout) begin
               acc_nxt = add_sum;
               lo_nxt  = {lo[width-2:0], 1'b1};
            end else begin
               acc_nxt = add_x;
               lo_nxt  = {lo[width-2:0], 1'b0};
            end
         end
         default: ;
      endcase
   end

   // Operand latch and working registers; contents only matter after a load.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q <= op_in;
         lo   <= a_i;
         b_q  <= b_i;
         acc  <= '0;
      end else if (pass) begin
         acc  <= acc_nxt;
         lo   <= lo_nxt;
      end
   end

   // Result registers: written on entry to DONE, held otherwise.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         res_lo_o   <= '0;
         res_hi_o   <= '0;
         cout_o     <= 1'b0;
         div_zero_o <= 1'b0;
      end else if (accept && div_by_zero) begin
         res_lo_o   <= '1;
         res_hi_o   <= a_i;
         cout_o     <= 1'b0;
         div_zero_o <= 1'b1;
      end else if (finish) begin
         div_zero_o <= 1'b0;
         unique case (op_q)
            OP_ADD, OP_SUB: begin
               res_lo_o <= acc[width-1:0];
               res_hi_o <= '0;
               cout_o   <= acc[width];
            end
            default: begin
               // MUL: {hi,lo} = product; DIV: lo = quotient, hi = remainder.
               res_lo_o <= lo;
               res_hi_o <= acc[width-1:0];
               cout_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule
